hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
Pipeline control sequencer for the RV32I 5-stage core. It detects load-use hazards that forwarding cannot cover, flushes wrong-path instructions after a taken branch, and freezes the whole pipeline while data memory is busy. It also maintains saturating stall and flush performance counters. It sits beside the forwarding logic and drives the write-enable, flush and bubble controls of PC, IF/ID and ID/EX.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15)
CNT_W, 16, width of performance counters

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
IFID_rs1  input  5  rs1 of instruction in ID
IFID_rs2  input  5  rs2 of instruction in ID
IFID_use_rs1  input  1  ID instruction reads rs1
IFID_use_rs2  input  1  ID instruction reads rs2
IDEX_rd  input  5  rd of instruction in EX
IDEX_MemRead  input  1  EX instruction is a load
branch_taken  input  1  EX resolved taken branch/jump, PC redirect this cycle
mem_busy  input  1  data memory not ready; pipeline must hold
clr_counters  input  1  synchronous clear of both counters
PC_write  output  1  PC register load enable
IFID_write  output  1  IF/ID register load enable
IFID_flush  output  1  IF/ID loads a NOP
IDEX_bubble  output  1  ID/EX loads zeroed controls (bubble)
pipe_freeze  output  1  hold EX/MEM and MEM/WB (and everything upstream)
ctrl_state  output  2  current FSM state encoding
stall_count  output  CNT_W  stall cycles, saturating
flush_count  output  CNT_W  branch flushes, saturating

Behaviour:
- States: RUN=2'b00, LU_STALL=2'b01, MEM_WAIT=2'b10. Reset -> RUN, stall_count=0, flush_count=0, bubble counter=0.
- While rst=1: PC_write=0, IFID_write=0, IFID_flush=1, IDEX_bubble=1, pipe_freeze=0.
- Control outputs are combinational from state and current inputs (same-cycle response). Counters and state are registered.
- Load-use (lu): IDEX_MemRead && IDEX_rd!=0 && ((IFID_use_rs1 && IFID_rs1==IDEX_rd) || (IFID_use_rs2 && IFID_rs2==IDEX_rd)).
- Default outputs: PC_write=1, IFID_write=1, IFID_flush=0, IDEX_bubble=0, pipe_freeze=0.
- Priority in every state: mem_busy > branch_taken > lu/stall.
- RUN:
  - If mem_busy: all enables 0, pipe_freeze=1, flush/bubble 0; next MEM_WAIT, saved return state RUN.
  - Else if branch_taken: PC_write=1, IFID_flush=1, IDEX_bubble=1; flush_count+1; stay RUN.
  - Else if lu: PC_write=0, IFID_write=0, IDEX_bubble=1; stall_count+1. If LOAD_STALL_CYCLES>1, load remaining count LOAD_STALL_CYCLES-1 and go to LU_STALL; else stay RUN.
- LU_STALL (hazard no longer visible, the load is in MEM): PC_write=0, IFID_write=0, IDEX_bubble=1; stall_count+1; decrement remaining count; go to RUN when it reaches 0.
  - If mem_busy: freeze instead, keep the count, go to MEM_WAIT with return state LU_STALL.
  - If branch_taken: flush as in RUN, abandon the remaining count, go to RUN.
- MEM_WAIT: pipe_freeze=1, all enables 0, no flush or bubble; stall_count+1 each cycle. branch_taken is ignored because the EX instruction is held and re-presents the branch after the freeze. When mem_busy=0, apply the return state's rules in the same cycle and transition accordingly.
- Counters: increment saturates at 2^CNT_W-1. clr_counters forces 0 and wins over any increment in the same cycle.
- rst mid-stall or mid-freeze: next state RUN and the remaining count is cleared; no residual bubbles after rst is released.

Test Plan:
1. LOAD_STALL_CYCLES=1: lw x5 in EX (IDEX_MemRead=1, IDEX_rd=5), ID has rs1=5, use_rs1=1 -> exactly 1 cycle with PC_write=0, IFID_write=0, IDEX_bubble=1; stall_count 0->1; state stays RUN.
2. LOAD_STALL_CYCLES=3, same hazard -> 3 consecutive bubble cycles; ctrl_state RUN, LU_STALL, LU_STALL, then RUN; stall_count=3. IDEX_rd=0 with MemRead -> no stall.
3. branch_taken=1 in RUN with a load-use also present -> IFID_flush=1, IDEX_bubble=1, PC_write=1 in that cycle; flush_count+1; stall_count unchanged.
4. LOAD_STALL_CYCLES=3: mem_busy high for 4 cycles during the 2nd bubble -> pipe_freeze=1 for 4 cycles; state MEM_WAIT then back to LU_STALL; total bubble cycles still 3; stall_count=7.
5. stall_count preloaded near 0xFFFF (CNT_W=16) by a long mem_busy -> holds at 0xFFFF. clr_counters with a simultaneous stall -> 0.
6. Assert rst during LU_STALL -> next cycle RUN; reset output values during rst; after release the hazard-free stream flows with PC_write=1.

Source files
------------

// File: rtl/hazard_sequencer.sv
// ---------------------------------------------------------------------------
// hazard_sequencer
//
// Pipeline control sequencer for the RV32I 5-stage core. It works alongside
// the forwarding unit and handles the three cases that forwarding cannot fix:
//   * load-use hazards: the ID instruction needs a value that a load in EX
//     has not fetched yet, so bubbles go into ID/EX while PC and IF/ID hold;
//   * taken branches/jumps resolved in EX: the wrong-path instructions in
//     IF/ID and ID/EX are squashed;
//   * data-memory wait states: the whole pipeline freezes until memory is
//     ready again.
// It also keeps saturating performance counters for stall cycles and branch
// flushes.
//
// Parameters
//   LOAD_STALL_CYCLES  bubbles inserted per load-use hazard (1..15)
//   CNT_W              width of the performance counters
//
// Ports
//   clk           in   system clock, rising-edge active
//   rst           in   synchronous active-high reset
//   IFID_rs1      in   [4:0] rs1 of the instruction in ID
//   IFID_rs2      in   [4:0] rs2 of the instruction in ID
//   IFID_use_rs1  in   ID instruction reads rs1
//   IFID_use_rs2  in   ID instruction reads rs2
//   IDEX_rd       in   [4:0] rd of the instruction in EX
//   IDEX_MemRead  in   EX instruction is a load
//   branch_taken  in   EX resolved a taken branch/jump this cycle
//   mem_busy      in   data memory not ready, pipeline must hold
//   clr_counters  in   synchronous clear of both counters
//   PC_write      out  PC register load enable
//   IFID_write    out  IF/ID register load enable
//   IFID_flush    out  IF/ID loads a NOP
//   IDEX_bubble   out  ID/EX loads zeroed controls
//   pipe_freeze   out  hold EX/MEM, MEM/WB and everything upstream
//   ctrl_state    out  [1:0] current FSM state (RUN=0, LU_STALL=1, MEM_WAIT=2)
//   stall_count   out  [CNT_W-1:0] stall cycles, saturating
//   flush_count   out  [CNT_W-1:0] branch flushes, saturating
// ---------------------------------------------------------------------------
module hazard_sequencer #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic             IFID_use_rs1,
  input  logic             IFID_use_rs2,
  input  logic [4:0]       IDEX_rd,
  input  logic             IDEX_MemRead,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             clr_counters,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic             pipe_freeze,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  // Number of extra bubbles loaded into the remaining-count register when a
  // load-use hazard is first seen (the first bubble is issued from RUN).
  localparam logic [3:0] EXTRA_BUBBLES = 4'(LOAD_STALL_CYCLES - 1);

  state_t           r_state;
  state_t           r_retState;
  logic [3:0]       r_remain;
  logic [CNT_W-1:0] r_stallCount;
  logic [CNT_W-1:0] r_flushCount;

  state_t           w_nextState;
  state_t           w_nextRet;
  state_t           w_evalState;
  logic [3:0]       w_nextRemain;
  logic             w_stallInc;
  logic             w_flushInc;
  logic             w_lu;

  // A load-use hazard exists when the load in EX writes a real register that
  // the ID instruction actually reads. x0 is never a hazard because its value
  // is constant.
  assign w_lu = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                ((IFID_use_rs1 && (IFID_rs1 == IDEX_rd)) ||
                 (IFID_use_rs2 && (IFID_rs2 == IDEX_rd)));

  // While memory is stalled the pipeline is frozen, so the state we were in
  // before the freeze is the one whose rules apply once memory is ready.
  // Evaluating that state directly lets the release cycle act in the same
  // cycle instead of wasting one cycle returning to it.
  assign w_evalState = (r_state == MEM_WAIT) ? r_retState : r_state;

  // Next-state and control outputs. Priority is memory wait, then taken
  // branch, then load-use/pending bubbles, in every state.
  always_comb begin
    PC_write     = 1'b1;
    IFID_write   = 1'b1;
    IFID_flush   = 1'b0;
    IDEX_bubble  = 1'b0;
    pipe_freeze  = 1'b0;
    w_nextState  = r_state;
    w_nextRet    = r_retState;
    w_nextRemain = r_remain;
    w_stallInc   = 1'b0;
    w_flushInc   = 1'b0;

    if (rst) begin
      // Reset holds fetch and fills the front of the pipe with NOPs.
      PC_write     = 1'b0;
      IFID_write   = 1'b0;
      IFID_flush   = 1'b1;
      IDEX_bubble  = 1'b1;
      w_nextState  = RUN;
      w_nextRet    = RUN;
      w_nextRemain = 4'd0;
    end else if (mem_busy) begin
      // Freeze everything; the pending bubble count is kept so the stall
      // resumes exactly where it left off. A branch in EX is held and will
      // be presented again after the freeze, so it is ignored here.
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      pipe_freeze = 1'b1;
      w_stallInc  = 1'b1;
      w_nextState = MEM_WAIT;
      w_nextRet   = w_evalState;
    end else if (branch_taken) begin
      // Squash the wrong-path instructions; any outstanding load-use bubbles
      // belong to the squashed path and are dropped.
      IFID_flush   = 1'b1;
      IDEX_bubble  = 1'b1;
      w_flushInc   = 1'b1;
      w_nextState  = RUN;
      w_nextRemain = 4'd0;
    end else if (w_evalState == LU_STALL) begin
      // The load has moved on to MEM so the hazard is no longer visible;
      // keep inserting bubbles until the count runs out.
      PC_write     = 1'b0;
      IFID_write   = 1'b0;
      IDEX_bubble  = 1'b1;
      w_stallInc   = 1'b1;
      w_nextRemain = r_remain - 4'd1;
      w_nextState  = (r_remain <= 4'd1) ? RUN : LU_STALL;
    end else begin
      w_nextState = RUN;
      if (w_lu) begin
        PC_write    = 1'b0;
        IFID_write  = 1'b0;
        IDEX_bubble = 1'b1;
        w_stallInc  = 1'b1;
        if (LOAD_STALL_CYCLES > 1) begin
          w_nextRemain = EXTRA_BUBBLES;
          w_nextState  = LU_STALL;
        end
      end
    end
  end

  // State, pending bubble count and performance counters. Counter clear has
  // priority over an increment in the same cycle, and counters stick at
  // all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_retState   <= RUN;
      r_remain     <= 4'd0;
      r_stallCount <= '0;
      r_flushCount <= '0;
    end else begin
      r_state    <= w_nextState;
      r_retState <= w_nextRet;
      r_remain   <= w_nextRemain;

      if (clr_counters) begin
        r_stallCount <= '0;
      end else if (w_stallInc && (r_stallCount != {CNT_W{1'b1}})) begin
        r_stallCount <= r_stallCount + 1'b1;
      end

      if (clr_counters) begin
        r_flushCount <= '0;
      end else if (w_flushInc && (r_flushCount != {CNT_W{1'b1}})) begin
        r_flushCount <= r_flushCount + 1'b1;
      end
    end
  end

  assign ctrl_state  = r_state;
  assign stall_count = r_stallCount;
  assign flush_count = r_flushCount;

endmodule
